score_scan_display: RTL

SCORE_SCAN_DISPLAY -- requirements
Module: score_scan_display

---
 rtl/score_scan_display.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/score_scan_display.sv
// score_scan_display
//   BCD score accumulator with a multiplexed, active-low seven-segment scan.
//   Additions of 0..9 ripple a decimal carry through every digit in one cycle.
//   On overflow the score either wraps or saturates at all nines, and a sticky
//   flag is raised. The display scans one digit per PRESCALE+1 cycles.
//
// Parameters
//   DIGITS   number of BCD digits / display positions (1..8)
//   PRESCALE scan dwell per digit is PRESCALE+1 sclk cycles (0..65535)
//   SAT      0 = wrap modulo 10^DIGITS, 1 = saturate at all nines
//
// Ports
//   sclk       clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous score/overflow clear, beats add_valid
//   freeze     ignore additions while high (scan keeps running)
//   add_valid  one-cycle add strobe
//   add_val    points to add; 10..15 are ignored
//   an         active-low digit enables, an[0] = least significant digit
//   seg        active-low segments {g,f,e,d,c,b,a}
//   score_bcd  registered BCD score, nibble 0 = least significant digit
//   overflow   sticky overflow flag
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank zero digits above the most significant
//                          nonzero digit; digit 0 always displays.

module score_scan_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 0,
  parameter int unsigned SAT      = 0
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  freeze,
  input  logic                  add_valid,
  input  logic [3:0]            add_val,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow
);

  localparam int unsigned      IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [15:0]      PRESC_MAX = 16'(PRESCALE);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  logic [4*DIGITS-1:0] score_q, score_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [4*DIGITS-1:0] sum_bcd;
  logic                sum_carry;
  logic [3:0]          sel_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Decimal ripple adder: add_val enters at digit 0, each digit sum is at most
  // 9+9+1 so a single subtract-10 correction keeps every nibble in 0..9.
  always_comb begin
    logic [4:0] s;
    logic       carry;
    s       = '0;
    carry   = 1'b0;
    sum_bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      s = {1'b0, score_q[4*i +: 4]} + {4'b0, carry};
      if (i == 0) begin
        s = s + {1'b0, add_val};
      end
      if (s > 5'd9) begin
        s     = s - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_bcd[4*i +: 4] = s[3:0];
    end
    sum_carry = carry;
  end

  always_comb begin
    score_d    = score_q;
    overflow_d = overflow_q;
    if (clr) begin
      score_d    = '0;
      overflow_d = 1'b0;
    end else if (add_valid && !freeze && (add_val <= 4'd9)) begin
      score_d = sum_bcd;
      if (sum_carry) begin
        overflow_d = 1'b1;
        if (SAT != 0) begin
          score_d = {DIGITS{4'h9}};
        end
      end
    end
  end

  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // an/seg are both derived from the same idx_q and score_q each cycle, so the
  // registered pair always matches; a score change lands on the next update.
  always_comb begin
    an_d      = '1;
    sel_digit = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        an_d[k]   = 1'b0;
        sel_digit = score_q[4*k +: 4];
      end
    end
    seg_d = seg_decode(sel_digit);
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic nz_above;
      nz_above = 1'b0;
      // Walk down from the top digit; a position is leading-zero only while
      // it and everything above it are zero. Digit 0 is never blanked.
      for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
        nz_above = nz_above | (score_q[4*k +: 4] != 4'd0);
        if ((IDX_W'(k) == idx_q) && !nz_above) begin
          seg_d = SEG_BLANK;
        end
      end
    end
`endif
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      score_q    <= '0;
      overflow_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      score_q    <= score_d;
      overflow_q <= overflow_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign score_bcd = score_q;
  assign overflow  = overflow_q;

endmodule
